// File: rtl/adder_seq_wide.sv
// Multi-cycle wide adder: one 16-bit combinational adder is reused once per slice,
// LSB slice first, with the inter-slice carry held in a register.

module adder (
    output logic        cout,
    output logic [15:0] sum,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
endmodule

module adder_seq_wide #(
    parameter int NUM_SLICES = 4,
    parameter int W          = 16 * NUM_SLICES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout
);
    localparam int SW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready and out_valid are decoded from the state register only.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] slice_idx;
    logic          carry_q;
    logic [W-1:0]  sum_q;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [15:0]   slice_a;
    logic [15:0]   slice_b;
    logic [15:0]   add_sum;
    logic          add_cout;
    logic          last_slice;

    assign last_slice = (slice_idx == SW'(NUM_SLICES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Slice selection with constant part-selects keeps every index in range for any NUM_SLICES.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (slice_idx == SW'(i)) begin
                slice_a = op_a[16*i +: 16];
                slice_b = op_b[16*i +: 16];
            end
        end
    end

    adder u_adder (
        .cout (add_cout),
        .sum  (add_sum),
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slice_idx <= '0;
            carry_q   <= 1'b0;
            sum_q     <= '0;
            out_cout  <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a      <= in_a;
                        op_b      <= in_b;
                        carry_q   <= in_cin;
                        slice_idx <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NUM_SLICES; i++) begin
                        if (slice_idx == SW'(i)) begin
                            sum_q[16*i +: 16] <= add_sum;
                        end
                    end
                    carry_q <= add_cout;
                    if (last_slice) begin
                        out_cout  <= add_cout;
                        slice_idx <= '0;
                    end else begin
                        slice_idx <= slice_idx + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum = sum_q;
endmodule

// File: tb/tb_adder_seq_wide.sv
// Directed bench for adder_seq_wide: a 4-slice instance for the main checks and a
// 1-slice instance for the single-slice corner.

module tb_adder_seq_wide;
    localparam int NS = 4;
    localparam int W  = 16 * NS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
    logic [W-1:0] in_a, in_b, out_sum;

    logic         s1_in_valid, s1_in_ready, s1_in_cin, s1_out_valid, s1_out_ready, s1_out_cout;
    logic [15:0]  s1_in_a, s1_in_b, s1_out_sum;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_seq_wide #(.NUM_SLICES(NS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    adder_seq_wide #(.NUM_SLICES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_in_valid),
        .in_ready  (s1_in_ready),
        .in_a      (s1_in_a),
        .in_b      (s1_in_b),
        .in_cin    (s1_in_cin),
        .out_valid (s1_out_valid),
        .out_ready (s1_out_ready),
        .out_sum   (s1_out_sum),
        .out_cout  (s1_out_cout)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE, check latency and result, hold it for 'hold' cycles, consume it.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] es, input logic ec, input int hold);
        int n;
        chk("idle_in_ready", W'(in_ready), W'(1));
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a = '1; in_b = '1; in_cin = 1'b1;
        chk("run_in_ready", W'(in_ready), W'(0));
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", W'(n), W'(NS));
        chk("sum", out_sum, es);
        chk("cout", W'(out_cout), W'(ec));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", W'(out_valid), W'(1));
            chk("hold_sum", out_sum, es);
            chk("hold_cout", W'(out_cout), W'(ec));
            chk("hold_in_ready", W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("consume_valid", W'(out_valid), W'(0));
        chk("consume_in_ready", W'(in_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] ra, rb, exp_s;
        logic         rc, exp_c;
        int           n, prev_acc, results;

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        s1_in_valid = 1'b0; s1_in_a = '0; s1_in_b = '0; s1_in_cin = 1'b0; s1_out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_sum", out_sum, W'(0));
        chk("rst_out_cout", W'(out_cout), W'(0));

        // Full ripple through every slice.
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 0);
        run_op(64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 0);
        run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
               64'h0001_0000_0001_0000, 1'b0, 0);
        // Backpressure for six cycles.
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
               64'h2222_2222_2222_2212, 1'b0, 6);
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h1, 1'b1, 0);

        // Reset during the second RUN cycle of a carry-heavy add.
        out_ready = 1'b1;
        in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'h1; in_cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        chk("midrst_in_ready", W'(in_ready), W'(1));
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_out_sum", out_sum, W'(0));
        chk("midrst_out_cout", W'(out_cout), W'(0));
        run_op(64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 0);

        // Back-to-back with in_valid held high and the consumer always ready.
        out_ready = 1'b1;
        in_valid = 1'b1;
        prev_acc = 0;
        results = 0;
        for (int i = 0; i < 20; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            {exp_c, exp_s} = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            in_a = ra; in_b = rb; in_cin = rc;
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            chk("b2b_ready_timeout", W'(n < 20), W'(1));
            tick();
            if (i > 0) chk("b2b_spacing", W'(cyc - prev_acc), W'(NS + 2));
            prev_acc = cyc;
            n = 0;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            chk("b2b_latency", W'(n), W'(NS));
            chk("b2b_sum", out_sum, exp_s);
            chk("b2b_cout", W'(out_cout), W'(exp_c));
            if (out_valid) results++;
            if (i == 19) in_valid = 1'b0;
        end
        tick();
        chk("b2b_results", W'(results), W'(20));
        repeat (NS + 2) begin
            tick();
            chk("b2b_no_extra", W'(out_valid), W'(0));
        end
        out_ready = 1'b0;

        // Single-slice instance.
        chk("s1_idle_ready", W'(s1_in_ready), W'(1));
        s1_in_a = 16'hFFFF; s1_in_b = 16'hFFFF; s1_in_cin = 1'b1; s1_in_valid = 1'b1;
        tick();
        s1_in_valid = 1'b0;
        chk("s1_run_valid", W'(s1_out_valid), W'(0));
        tick();
        chk("s1_valid", W'(s1_out_valid), W'(1));
        chk("s1_sum", W'(s1_out_sum), W'(16'hFFFF));
        chk("s1_cout", W'(s1_out_cout), W'(1));
        s1_out_ready = 1'b1;
        tick();
        s1_out_ready = 1'b0;
        chk("s1_consume_valid", W'(s1_out_valid), W'(0));
        chk("s1_consume_ready", W'(s1_in_ready), W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/adder_seq_wide.md
Name: adder_seq_wide

Overview:
- Multi-cycle wide-operand adder built around one instance of the existing 16-bit combinational `adder` (ports cout, sum, a, b, cin).
- Accepts a NUM_SLICES*16-bit add request over a valid/ready handshake.
- Feeds the adder one 16-bit slice per cycle, LSB slice first, chaining cout into the next slice's cin through a register.
- Returns the registered wide sum and carry-out over a second valid/ready handshake; sits directly upstream of and wraps the adder.

Parameters:
- NUM_SLICES, 4, number of 16-bit slices; operand width W = 16*NUM_SLICES; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry into slice 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  registered sum.
- out_cout  output  1  registered carry-out of the top slice.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset: rst_n sampled low at a clk edge forces state=IDLE, slice_idx=0, carry_q=0, sum_q=0, out_cout=0, out_valid=0. in_ready is 1 in the first cycle after the reset edge. A reset mid-RUN or mid-DONE aborts the operation and discards the result; no out_valid is produced for it.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE: on an edge with in_valid=1, latch in_a, in_b into operand registers; carry_q<=in_cin; slice_idx<=0; go to RUN.
- RUN, each cycle:
  - Adder inputs are a=op_a[16*slice_idx +: 16], b=op_b[16*slice_idx +: 16], cin=carry_q.
  - At the edge: sum_q[16*slice_idx +: 16]<=adder sum; carry_q<=adder cout; slice_idx<=slice_idx+1.
  - When slice_idx==NUM_SLICES-1: out_cout<=adder cout, slice_idx<=0, go to DONE.
- DONE: out_sum=sum_q and out_cout are held stable while out_valid=1 and out_ready=0. On an edge with out_ready=1, go to IDLE. in_ready rises the following cycle; a request is never accepted in the same cycle a result is consumed.
- Latency: request accepted at edge k. out_valid is high starting the cycle after edge k+NUM_SLICES, so NUM_SLICES RUN cycles. Throughput is one request per NUM_SLICES+2 cycles minimum.
- Width rules:
  - No truncation; the wide sum is exactly (in_a+in_b+in_cin) mod 2^W.
  - out_cout = bit W of the full sum.
  - slice_idx width is clog2(NUM_SLICES), minimum 1 bit; it never exceeds NUM_SLICES-1.
- NUM_SLICES=1: RUN lasts exactly one cycle; the behaviour is otherwise identical.
- in_valid held high while busy: ignored, with no side effects; the operand registers change only on IDLE acceptance.
- out_ready high while not in DONE: ignored.
- Ports in_a, in_b, in_cin are don't-care except in IDLE with in_valid=1.
- Adder instance is purely combinational; its sum and cout are consumed only through the internal registers. No combinational path from inputs to outputs; in_ready and out_valid are decoded from state registers only.

Test Plan:
- NUM_SLICES=4, in_a=64'hFFFF_FFFF_FFFF_FFFF, in_b=64'h1, in_cin=0 -> out_sum=0, out_cout=1; out_valid rises exactly 4 cycles after the accept edge; full carry ripples through all slices.
- NUM_SLICES=4, in_a=0, in_b=0, in_cin=1 -> out_sum=64'h1, out_cout=0. Then in_a=64'h0000_FFFF_0000_FFFF, in_b=64'h0000_0001_0000_0001, in_cin=0 -> out_sum=64'h0001_0000_0001_0000, out_cout=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> out_valid stays 1 and out_sum/out_cout stay unchanged; in_ready stays 0. Raise out_ready -> out_valid drops next cycle and in_ready=1 the cycle after that edge.
- Reset mid-operation: drive rst_n=0 for one edge during the second RUN cycle -> next cycle state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0. A new request then completes correctly with no leftover carry.
- Back-to-back: in_valid held high with 20 random operand pairs and out_ready=1 -> each result matches the reference model (a+b+cin), each accept is spaced NUM_SLICES+2 cycles apart, and no request is lost or duplicated.
- NUM_SLICES=1: in_a=16'hFFFF, in_b=16'hFFFF, in_cin=1 -> out_sum=16'hFFFF, out_cout=1, out_valid one cycle after acceptance.
